// File: rtl/vec_alu_pkg.sv
// Shared types for the time-multiplexed vector ALU: opcodes, FSM states, default lane type.
package vec_alu_pkg;

    localparam int ELEM_W_DEF = 16;

    typedef logic [ELEM_W_DEF-1:0] lane_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_vec_seq_if.sv
// Operand/result bus of the vector ALU.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// the sender holds valid and payload stable until that edge, ready may depend on valid.
interface alu_vec_seq_if #(
    parameter int ELEMENT_W = 16,
    parameter int LANES     = 16
);
    logic                              in_valid;
    logic                              in_ready;
    logic [LANES-1:0][ELEMENT_W-1:0]   vectorA;
    logic [LANES-1:0][ELEMENT_W-1:0]   vectorB;
    logic [ELEMENT_W-1:0]              scalar;
    logic                              operand_flag;
    logic [2:0]                        sel;
    logic [LANES-1:0]                  lane_mask;
    logic                              out_valid;
    logic                              out_ready;
    logic [LANES-1:0][ELEMENT_W-1:0]   result;

    modport master (
        output in_valid, vectorA, vectorB, scalar, operand_flag, sel, lane_mask, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, vectorA, vectorB, scalar, operand_flag, sel, lane_mask, out_ready,
        output in_ready, out_valid, result
    );

endinterface

// File: rtl/vec_lane_alu.sv
// Combinational single-lane ALU; a disabled lane passes operand a through unchanged.
module vec_lane_alu
    import vec_alu_pkg::*;
#(
    parameter int ELEMENT_W = 16
) (
    input  logic [ELEMENT_W-1:0] a,
    input  logic [ELEMENT_W-1:0] b,
    input  op_e                  op,
    input  logic                 en,
    output logic [ELEMENT_W-1:0] y
);

    localparam int SH_W = (ELEMENT_W > 1) ? $clog2(ELEMENT_W) : 1;

    logic [SH_W-1:0]      sh;
    logic [ELEMENT_W-1:0] r;

    assign sh = b[SH_W-1:0];

    always_comb begin
        r = a;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_MUL:  r = a * b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SHL:  r = a << sh;
            OP_SHR:  r = a >> sh;
            default: r = a;
        endcase
        y = en ? r : a;
    end

endmodule

// File: rtl/alu_vec_seq.sv
// Vector ALU that runs a LANES-wide op on PHYS_LANES lane ALUs, one beat per cycle,
// and holds the registered result until the consumer takes it.
module alu_vec_seq
    import vec_alu_pkg::*;
#(
    parameter int ELEMENT_W  = 16,
    parameter int LANES      = 16,
    parameter int PHYS_LANES = 4
) (
    input  logic          clk,
    input  logic          rst,
    alu_vec_seq_if.slave  bus,
    output logic          busy,
    output state_e        fsm_state
);

    localparam int NBEATS = LANES / PHYS_LANES;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    if (LANES % PHYS_LANES != 0) begin : g_lane_check
        $error("alu_vec_seq: PHYS_LANES (%0d) must divide LANES (%0d)", PHYS_LANES, LANES);
    end

    // Beat-major view: lane i lives at [i / PHYS_LANES][i % PHYS_LANES], same bit layout as the bus.
    typedef logic [NBEATS-1:0][PHYS_LANES-1:0][ELEMENT_W-1:0] beat_vec_t;
    typedef logic [LANES-1:0][ELEMENT_W-1:0]                  vec_t;

    state_e                                  state;
    logic [BEAT_W-1:0]                       beat;
    beat_vec_t                               a_q;
    beat_vec_t                               b_q;
    beat_vec_t                               result_q;
    logic [NBEATS-1:0][PHYS_LANES-1:0]       mask_q;
    op_e                                     op_q;
    logic                                    out_valid_q;
    logic                                    in_ready;
    logic                                    accept;
    logic                                    last_beat;
    vec_t                                    b_sel;
    logic [PHYS_LANES-1:0][ELEMENT_W-1:0]    lane_y;

    // Retiring in DONE frees the operand registers, so a new op may be taken on that same edge.
    assign in_ready  = !rst && ((state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready));
    assign accept    = bus.in_valid && in_ready;
    assign last_beat = (beat == BEAT_W'(NBEATS - 1));

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            b_sel[i] = bus.operand_flag ? bus.scalar : bus.vectorB[i];
        end
    end

    for (genvar p = 0; p < PHYS_LANES; p++) begin : g_lane
        vec_lane_alu #(.ELEMENT_W(ELEMENT_W)) u_alu (
            .a  (a_q[beat][p]),
            .b  (b_q[beat][p]),
            .op (op_q),
            .en (mask_q[beat][p]),
            .y  (lane_y[p])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            beat        <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            mask_q      <= '0;
            op_q        <= OP_ADD;
        end else begin
            if (accept) begin
                a_q    <= bus.vectorA;
                b_q    <= b_sel;
                mask_q <= bus.lane_mask;
                op_q   <= op_e'(bus.sel);
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        beat  <= '0;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    result_q[beat] <= lane_y;
                    if (last_beat) begin
                        beat        <= '0;
                        state       <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        beat        <= '0;
                        state       <= accept ? ST_BUSY : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign busy          = (state != ST_IDLE);
    assign fsm_state     = state;

endmodule

// File: tb/tb_alu_vec_seq.sv
// Bench for alu_vec_seq: vector table, random ops, back-to-back retire/accept and reset abort.
module tb_alu_vec_seq;
    import vec_alu_pkg::*;

    localparam int EW     = 16;
    localparam int LANES  = 16;
    localparam int NBEATS = 4;
    localparam int VW     = EW * LANES;
    localparam int NTBL   = 11;

    typedef logic [LANES-1:0][EW-1:0] vec_t;

    // A[i] = a_base + i*a_step, B[i] = b_base + i*b_step; exp_first/exp_last are lanes 0 and 15.
    typedef struct packed {
        logic [2:0]  op;
        logic        flag;
        logic [15:0] a_base;
        logic [15:0] a_step;
        logic [15:0] b_base;
        logic [15:0] b_step;
        logic [15:0] scalar;
        logic [15:0] mask;
        logic [15:0] exp_first;
        logic [15:0] exp_last;
    } rec_t;

    logic   clk = 1'b0;
    logic   rst;
    logic   busy;
    state_e fsm_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [VW-1:0] exp_q[$];
    rec_t          tbl[NTBL];

    alu_vec_seq_if #(.ELEMENT_W(EW), .LANES(LANES)) bus ();

    alu_vec_seq #(.ELEMENT_W(EW), .LANES(LANES), .PHYS_LANES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t make_vec(input logic [15:0] base, input logic [15:0] step);
        vec_t v;
        for (int i = 0; i < LANES; i++) v[i] = base + 16'(i) * step;
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < LANES; i++) v[i] = 16'($urandom);
        return v;
    endfunction

    function automatic vec_t model(input vec_t a, input vec_t b, input logic [15:0] s,
                                   input logic f, input logic [2:0] op, input logic [15:0] m);
        vec_t        r;
        logic [15:0] bb;
        logic [31:0] p;
        for (int i = 0; i < LANES; i++) begin
            bb = f ? s : b[i];
            p  = 32'(a[i]) * 32'(bb);
            if (!m[i]) r[i] = a[i];
            else begin
                case (op)
                    3'd0:    r[i] = a[i] + bb;
                    3'd1:    r[i] = a[i] - bb;
                    3'd2:    r[i] = p[15:0];
                    3'd3:    r[i] = a[i] & bb;
                    3'd4:    r[i] = a[i] | bb;
                    3'd5:    r[i] = a[i] ^ bb;
                    3'd6:    r[i] = a[i] << bb[3:0];
                    default: r[i] = a[i] >> bb[3:0];
                endcase
            end
        end
        return r;
    endfunction

    // Offers one op, waits for the accepting edge, then scrambles the operand inputs.
    task automatic send_op(input vec_t a, input vec_t b, input logic [15:0] s, input logic f,
                           input logic [2:0] op, input logic [15:0] m, input bit push);
        bit ok;
        bus.vectorA      = a;
        bus.vectorB      = b;
        bus.scalar       = s;
        bus.operand_flag = f;
        bus.sel          = op;
        bus.lane_mask    = m;
        bus.in_valid     = 1'b1;
        if (push) exp_q.push_back(model(a, b, s, f, op, m));
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            if (bus.in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
        bus.in_valid     = 1'b0;
        bus.vectorB      = rand_vec();
        bus.vectorA      = rand_vec();
        bus.scalar       = 16'($urandom);
        bus.operand_flag = ~f;
        bus.sel          = 3'($urandom_range(0, 7));
        bus.lane_mask    = 16'($urandom);
    endtask

    task automatic wait_result(output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(posedge clk);
            #1;
            cyc = k;
            if (k == 1) chk("busy_in_ready", {30'd0, busy, bus.in_ready}, 32'd2);
            if (bus.out_valid) seen = 1'b1;
        end
        if (!seen) chk("out_valid_timeout", 32'(seen), 32'd1);
    endtask

    task automatic check_front(input string name);
        logic [VW-1:0] e;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk_vec(name, bus.result, e);
        end
    endtask

    task automatic retire();
        check_front("result");
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("retire_out_valid", 32'(bus.out_valid), 32'd0);
    endtask

    task automatic run_table(input int t);
        int cyc;
        send_op(make_vec(tbl[t].a_base, tbl[t].a_step), make_vec(tbl[t].b_base, tbl[t].b_step),
                tbl[t].scalar, tbl[t].flag, tbl[t].op, tbl[t].mask, 1'b1);
        wait_result(cyc);
        chk("latency", 32'(cyc), 32'(NBEATS));
        chk("lane_first", 32'(bus.result[0]), 32'(tbl[t].exp_first));
        chk("lane_last", 32'(bus.result[LANES-1]), 32'(tbl[t].exp_last));
        if (t == 0) begin
            // Result must hold while the consumer stalls, and a new offer is refused.
            bus.in_valid = 1'b1;
            repeat (2) begin
                @(posedge clk);
                #1;
            end
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
            chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_state", 32'(fsm_state), 32'(ST_DONE));
            chk_vec("hold_result", bus.result, exp_q[0]);
            bus.in_valid = 1'b0;
        end
        retire();
    endtask

    initial begin
        int  cyc;
        bit  pulsed;
        vec_t ra, rb;
        logic [15:0] rs, rm;
        logic [2:0]  rop;
        logic        rf;

        tbl[0]  = '{3'd0, 1'b0, 16'h0000, 16'h0001, 16'd100,  16'h0000, 16'h0000, 16'hFFFF, 16'h0064, 16'h0073};
        tbl[1]  = '{3'd1, 1'b1, 16'h0005, 16'h0000, 16'h1111,  16'h0000, 16'h0007, 16'hFFFF, 16'hFFFE, 16'hFFFE};
        tbl[2]  = '{3'd2, 1'b0, 16'h0100, 16'h0000, 16'h0100,  16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
        tbl[3]  = '{3'd6, 1'b0, 16'h0001, 16'h0000, 16'h0013,  16'h0000, 16'h0000, 16'hFFFF, 16'h0008, 16'h0008};
        tbl[4]  = '{3'd5, 1'b0, 16'hAAAA, 16'h0000, 16'hFFFF,  16'h0000, 16'h0000, 16'h00FF, 16'h5555, 16'hAAAA};
        tbl[5]  = '{3'd7, 1'b0, 16'h8000, 16'h0000, 16'h000F,  16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 16'h0001};
        tbl[6]  = '{3'd3, 1'b0, 16'hF0F0, 16'h0000, 16'h3C3C,  16'h0000, 16'h0000, 16'hFFFF, 16'h3030, 16'h3030};
        tbl[7]  = '{3'd4, 1'b0, 16'h1200, 16'h0000, 16'h0034,  16'h0000, 16'h0000, 16'hFFFF, 16'h1234, 16'h1234};
        tbl[8]  = '{3'd2, 1'b0, 16'h0003, 16'h0001, 16'h1000,  16'h0000, 16'h0000, 16'hFFFF, 16'h3000, 16'h2000};
        tbl[9]  = '{3'd0, 1'b1, 16'hFFFF, 16'h0000, 16'h1234,  16'h0000, 16'h0002, 16'hFFFF, 16'h0001, 16'h0001};
        tbl[10] = '{3'd1, 1'b0, 16'h0000, 16'h0002, 16'h0001,  16'h0000, 16'h0000, 16'h8001, 16'hFFFF, 16'h001D};

        // Clock/reset
        rst              = 1'b1;
        bus.in_valid     = 1'b0;
        bus.out_ready    = 1'b0;
        bus.vectorA      = '0;
        bus.vectorB      = '0;
        bus.scalar       = '0;
        bus.operand_flag = 1'b0;
        bus.sel          = '0;
        bus.lane_mask    = '0;
        #1;
        chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk_vec("reset_result", bus.result, '0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_reset_state", 32'(fsm_state), 32'(ST_IDLE));

        for (int t = 0; t < NTBL; t++) run_table(t);

        for (int n = 0; n < 6; n++) begin
            ra  = rand_vec();
            rb  = rand_vec();
            rs  = 16'($urandom);
            rf  = 1'($urandom_range(0, 1));
            rop = 3'($urandom_range(0, 7));
            rm  = 16'($urandom);
            send_op(ra, rb, rs, rf, rop, rm, 1'b1);
            wait_result(cyc);
            chk("rand_latency", 32'(cyc), 32'(NBEATS));
            retire();
        end

        // Back-to-back: second op offered while the first is in DONE with out_ready high.
        send_op(rand_vec(), rand_vec(), 16'h0003, 1'b1, 3'd6, 16'hFFFF, 1'b1);
        wait_result(cyc);
        chk("b2b_first_latency", 32'(cyc), 32'(NBEATS));
        bus.out_ready    = 1'b1;
        bus.in_valid     = 1'b1;
        #1;
        chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
        check_front("b2b_first_result");
        send_op(make_vec(16'h0010, 16'h0001), make_vec(16'h0001, 16'h0000), 16'h0000, 1'b0,
                3'd1, 16'hFFFF, 1'b1);
        chk("b2b_out_valid_drop", 32'(bus.out_valid), 32'd0);
        chk("b2b_rebusy", 32'(fsm_state), 32'(ST_BUSY));
        wait_result(cyc);
        chk("b2b_second_latency", 32'(cyc), 32'(NBEATS));
        chk("b2b_second_lane3", 32'(bus.result[3]), 32'h0012);
        check_front("b2b_second_result");
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("b2b_retired", 32'(bus.out_valid), 32'd0);

        // Reset while beat 2 is about to be computed: op is dropped without a result.
        send_op(make_vec(16'h0007, 16'h0000), make_vec(16'h0009, 16'h0000), 16'h0000, 1'b0,
                3'd0, 16'hFFFF, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        chk("abort_in_ready", 32'(bus.in_ready), 32'd0);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk_vec("abort_result", bus.result, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_release_in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_release_busy", 32'(busy), 32'd0);
        pulsed = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) pulsed = 1'b1;
        end
        chk("abort_no_pulse", 32'(pulsed), 32'd0);
        run_table(0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
